ascon_perm_iter: RTL and testbench
==================================

Name: ascon_perm_iter

Overview:
- Parametrised, self-sequencing ASCON permutation engine; next generation of the single-round permutation datapath with begin/end XOR stages.
- Adds an internal round counter and FSM with a start/done handshake.
- Supports p^6, p^8 and p^12 per request, 1 or 2 rounds per clock, and rate 64 (ASCON-128) or 128 (ASCON-128a).
- Sits between the mode-level FSM and the state/key/data buses.

Parameters:
- UNROLL_G, 1, rounds per clock; legal values 1 or 2 (elaboration error otherwise).
- RATE_G, 64, rate in bits; legal values 64 or 128. Sets the data/cypher width and the key-injection words.

Ports:
- clock_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request pulse; accepted only when ready_o=1.
- load_i  in  1  1: source state = state_i; 0: source state = internal state register.
- nb_rounds_i  in  4  rounds to run; legal values 6, 8, 12.
- state_i  in  320  external state (type_state, x0..x4).
- key_i  in  128  key; sampled at accept.
- data_i  in  RATE_G  rate data; sampled at accept.
- en_xor_data_i  in  1  begin XOR of data into the rate words.
- en_xor_key_begin_i  in  1  begin XOR of key, for finalisation.
- en_xor_key_end_i  in  1  end XOR of key into x3,x4.
- en_xor_lsb_i  in  1  end XOR of 1 into bit 0 of x4 (domain separation).
- en_tag_i  in  1  capture the tag at completion.
- ready_o  out  1  high when IDLE.
- done_o  out  1  one-cycle pulse when the final state is registered.
- state_o  out  320  state register.
- cypher_o  out  RATE_G  rate words after the begin XOR.
- tag_o  out  128  {x3,x4} after the end XOR.

Behaviour:
- Reset: state_o, cypher_o and tag_o = 0; done_o = 0; ready_o = 1; FSM in IDLE. Applies at any time, including mid-run; the run is aborted and there is no done_o pulse.
- FSM IDLE -> RUN on start_i with a legal nb_rounds_i.
- Accept cycle, single register write:
  - state reg <= src ^ begin XORs.
  - cypher_o <= rate words of that value.
  - Latch key_i, nb_rounds_i and the end-stage/tag enables.
  - Round index r <= 12 - nb_rounds_i.
- Begin XOR, RATE_G=64:
  - data XOR into x0.
  - key XOR into {x1,x2}.
- Begin XOR, RATE_G=128:
  - data XOR into {x0,x1}.
  - key XOR into {x2,x3}.
- RUN, each cycle:
  - Apply UNROLL_G rounds (constant add, S-box layer, linear layer).
  - Round-i constant = {~i[3:0], i[3:0]}, XORed into x2 bits 7:0.
  - r += UNROLL_G.
- Last RUN cycle (r + UNROLL_G = 12):
  - Apply end XORs to the round output before registering.
  - If en_tag latched, tag_o <= {x3,x4}.
  - done_o = 1 in the following cycle; FSM -> IDLE.
- Latency: done_o asserts nb_rounds/UNROLL_G + 1 cycles after the accept edge.
  - Examples: 13 cycles for p^12 with U=1; 4 cycles for p^6 with U=2.
  - Back-to-back start is allowed in the same cycle done_o is high, because ready_o is already 1.
- start_i while RUN: ignored, no side effects.
- Illegal nb_rounds_i: start ignored; FSM stays IDLE.
- cypher_o and tag_o hold their value until the next capture.

Optional Feature:
- ASCON_PERM_ERR_EN.
- Defined:
  - Adds output err_o (1 bit, reset 0).
  - err_o is sticky-set by start_i while busy, or by start_i with an illegal nb_rounds_i.
  - Cleared only by reset_i.
- Undefined: no err_o port; those events are silently ignored as above.

Decomposition:
- ascon_pack holds:
  - type_state.
  - Round-constant function.
  - Legal round counts (6, 8, 12).
  - IV constants for ASCON-128/128a.
  - Enum for the FSM states.
- Sub-module ascon_round: one combinational round.
  - Inputs: state and round index. Output: state.
  - Instantiated UNROLL_G times in a chain.

Test Plan:
- Reset mid-run: pulse reset_i at RUN cycle 5 of p^12 -> all outputs 0, ready_o=1, no done_o; a new start runs cleanly.
- ASCON-128 init, U=1:
  - Stimulus: load_i=1, state_i = {IV 0x80400c0600000000, K, N}, nb=12, key XOR end, K = N = 0.
  - Required: done_o exactly 13 cycles after accept; state_o matches the golden model.
- Data absorb, U=2, RATE_G=64:
  - Stimulus: load_i=0, data 0x0123456789ABCDEF, nb=6, lsb XOR.
  - Required: cypher_o = x0 ^ data; done_o after 4 cycles; x4 bit 0 toggled versus the model without lsb.
- Finalisation, RATE_G=128, p^8:
  - Stimulus: key begin XOR into x2,x3; key end XOR; en_tag_i=1.
  - Required: tag_o = model {x3,x4}; done_o after 5 cycles (U=2).
- Illegal and busy starts:
  - Stimulus: nb_rounds_i=7, then start_i during RUN.
  - Required: FSM unchanged; the running permutation completes intact; err_o=1 with ASCON_PERM_ERR_EN defined.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared types and constants for the iterative ASCON permutation engine.
package ascon_pack;

    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } type_state;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } fsm_t;

    localparam logic [63:0] IV_128  = 64'h80400c0600000000;
    localparam logic [63:0] IV_128A = 64'h80800c0800000000;

    localparam logic [3:0] NB_P6  = 4'd6;
    localparam logic [3:0] NB_P8  = 4'd8;
    localparam logic [3:0] NB_P12 = 4'd12;

    function automatic logic [7:0] round_const(input logic [3:0] i);
        return {~i, i};
    endfunction

    function automatic logic legal_rounds(input logic [3:0] nb);
        return (nb == NB_P6) || (nb == NB_P8) || (nb == NB_P12);
    endfunction

    function automatic logic [63:0] ror64(
        input logic [63:0] x,
        input int unsigned n
    );
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant add, S-box layer, linear layer.
module ascon_round
    import ascon_pack::*;
(
    input  type_state   state_i,
    input  logic [3:0]  round_i,
    output type_state   state_o
);

    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;

    always_comb begin
        x0 = state_i.x0;
        x1 = state_i.x1;
        x2 = state_i.x2 ^ {56'd0, round_const(round_i)};
        x3 = state_i.x3;
        x4 = state_i.x4;

        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        state_o.x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        state_o.x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        state_o.x2 = x2 ^ ror64(x2, 1) ^ ror64(x2, 6);
        state_o.x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        state_o.x4 = x4 ^ ror64(x4, 7) ^ ror64(x4, 41);
    end

endmodule

// File: rtl/ascon_perm_iter.sv
// Self-sequencing ASCON permutation with begin/end XOR stages.
// Define ASCON_PERM_ERR_EN to add the sticky err_o output.
module ascon_perm_iter
    import ascon_pack::*;
#(
    parameter int UNROLL_G = 1,
    parameter int RATE_G   = 64
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              load_i,
    input  logic [3:0]        nb_rounds_i,
    input  logic [319:0]      state_i,
    input  logic [127:0]      key_i,
    input  logic [RATE_G-1:0] data_i,
    input  logic              en_xor_data_i,
    input  logic              en_xor_key_begin_i,
    input  logic              en_xor_key_end_i,
    input  logic              en_xor_lsb_i,
    input  logic              en_tag_i,
    output logic              ready_o,
    output logic              done_o,
    output logic [319:0]      state_o,
    output logic [RATE_G-1:0] cypher_o,
    output logic [127:0]      tag_o
`ifdef ASCON_PERM_ERR_EN
    ,
    output logic              err_o
`endif
);

    generate
        if (UNROLL_G != 1 && UNROLL_G != 2) begin : g_bad_unroll
            $error("ascon_perm_iter: UNROLL_G must be 1 or 2");
        end
        if (RATE_G != 64 && RATE_G != 128) begin : g_bad_rate
            $error("ascon_perm_iter: RATE_G must be 64 or 128");
        end
    endgenerate

    fsm_t              state_q, state_d;
    type_state         st_q;
    type_state         src;
    type_state         beg;
    type_state         fin;
    type_state         chain [UNROLL_G+1];
    logic [RATE_G-1:0] cy_d;
    logic [RATE_G-1:0] cy_q;
    logic [127:0]      tag_q;
    logic [127:0]      key_q;
    logic [3:0]        r_q;
    logic              end_key_q;
    logic              end_lsb_q;
    logic              tag_en_q;
    logic              fin_q;
    logic              done_q;
    logic              accept;
    logic              last;

    assign src    = load_i ? type_state'(state_i) : st_q;
    assign accept = (state_q == ST_IDLE) && start_i
                    && legal_rounds(nb_rounds_i);
    assign last   = (state_q == ST_RUN)
                    && (({1'b0, r_q} + 5'(UNROLL_G)) == 5'd12);

    // The rate and key-injection words move with the rate width.
    generate
        if (RATE_G == 64) begin : g_r64
            always_comb begin
                beg = src;
                if (en_xor_data_i)
                    beg.x0 = beg.x0 ^ data_i;
                if (en_xor_key_begin_i)
                    {beg.x1, beg.x2} = {beg.x1, beg.x2} ^ key_i;
            end
            assign cy_d = beg.x0;
        end else begin : g_r128
            always_comb begin
                beg = src;
                if (en_xor_data_i)
                    {beg.x0, beg.x1} = {beg.x0, beg.x1} ^ data_i;
                if (en_xor_key_begin_i)
                    {beg.x2, beg.x3} = {beg.x2, beg.x3} ^ key_i;
            end
            assign cy_d = {beg.x0, beg.x1};
        end
    endgenerate

    assign chain[0] = st_q;

    generate
        for (genvar k = 0; k < UNROLL_G; k++) begin : g_rnd
            ascon_round u_round (
                .state_i (chain[k]),
                .round_i (r_q + 4'(k)),
                .state_o (chain[k+1])
            );
        end
    endgenerate

    always_comb begin
        fin = chain[UNROLL_G];
        if (end_key_q)
            {fin.x3, fin.x4} = {fin.x3, fin.x4} ^ key_q;
        if (end_lsb_q)
            fin.x4[0] = ~fin.x4[0];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (last)   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            st_q      <= '0;
            cy_q      <= '0;
            tag_q     <= '0;
            key_q     <= '0;
            r_q       <= '0;
            end_key_q <= 1'b0;
            end_lsb_q <= 1'b0;
            tag_en_q  <= 1'b0;
            fin_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fin_q   <= last;
            done_q  <= fin_q;
            if (accept) begin
                st_q      <= beg;
                cy_q      <= cy_d;
                key_q     <= key_i;
                end_key_q <= en_xor_key_end_i;
                end_lsb_q <= en_xor_lsb_i;
                tag_en_q  <= en_tag_i;
                r_q       <= 4'd12 - nb_rounds_i;
            end else if (state_q == ST_RUN) begin
                st_q <= last ? fin : chain[UNROLL_G];
                r_q  <= r_q + 4'(UNROLL_G);
                if (last && tag_en_q)
                    tag_q <= {fin.x3, fin.x4};
            end
        end
    end

`ifdef ASCON_PERM_ERR_EN
    logic err_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)
            err_q <= 1'b0;
        else if (start_i && ((state_q == ST_RUN)
                 || !legal_rounds(nb_rounds_i)))
            err_q <= 1'b1;
    end

    assign err_o = err_q;
`endif

    assign ready_o  = (state_q == ST_IDLE);
    assign done_o   = done_q;
    assign state_o  = st_q;
    assign cypher_o = cy_q;
    assign tag_o    = tag_q;

endmodule

// File: tb/tb_ascon_perm_iter.sv
// Bench: three engine configurations run side by side against a
// table-driven S-box model of the permutation.
module tb_ascon_perm_iter;
    import ascon_pack::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic         load  = 1'b0;
    logic [3:0]   nb    = '0;
    logic [319:0] st_in = '0;
    logic [127:0] key   = '0;
    logic [127:0] data  = '0;
    logic en_d = 1'b0, en_kb = 1'b0, en_ke = 1'b0;
    logic en_lsb = 1'b0, en_tag = 1'b0;

    logic [2:0]   rdy, dn;
    logic [319:0] so [3];
    logic [63:0]  cy_a, cy_b;
    logic [127:0] cy_c;
    logic [127:0] tg [3];
`ifdef ASCON_PERM_ERR_EN
    logic [2:0]   er;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int uu [3] = '{1, 2, 2};
    int rr [3] = '{64, 64, 128};
    int nbs [3] = '{6, 8, 12};

    logic [319:0] m_st  [3] = '{default: '0};
    logic [127:0] m_cy  [3] = '{default: '0};
    logic [127:0] m_tag [3] = '{default: '0};

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int ROT1 [5] = '{19, 61, 1, 10, 7};
    localparam int ROT2 [5] = '{28, 39, 6, 17, 41};

    ascon_perm_iter #(.UNROLL_G(1), .RATE_G(64)) u_d0 (
        .clock_i(clk), .reset_i(rst), .start_i(start), .load_i(load),
        .nb_rounds_i(nb), .state_i(st_in), .key_i(key),
        .data_i(data[63:0]), .en_xor_data_i(en_d),
        .en_xor_key_begin_i(en_kb), .en_xor_key_end_i(en_ke),
        .en_xor_lsb_i(en_lsb), .en_tag_i(en_tag), .ready_o(rdy[0]),
        .done_o(dn[0]), .state_o(so[0]), .cypher_o(cy_a),
`ifdef ASCON_PERM_ERR_EN
        .err_o(er[0]),
`endif
        .tag_o(tg[0]));

    ascon_perm_iter #(.UNROLL_G(2), .RATE_G(64)) u_d1 (
        .clock_i(clk), .reset_i(rst), .start_i(start), .load_i(load),
        .nb_rounds_i(nb), .state_i(st_in), .key_i(key),
        .data_i(data[63:0]), .en_xor_data_i(en_d),
        .en_xor_key_begin_i(en_kb), .en_xor_key_end_i(en_ke),
        .en_xor_lsb_i(en_lsb), .en_tag_i(en_tag), .ready_o(rdy[1]),
        .done_o(dn[1]), .state_o(so[1]), .cypher_o(cy_b),
`ifdef ASCON_PERM_ERR_EN
        .err_o(er[1]),
`endif
        .tag_o(tg[1]));

    ascon_perm_iter #(.UNROLL_G(2), .RATE_G(128)) u_d2 (
        .clock_i(clk), .reset_i(rst), .start_i(start), .load_i(load),
        .nb_rounds_i(nb), .state_i(st_in), .key_i(key),
        .data_i(data), .en_xor_data_i(en_d),
        .en_xor_key_begin_i(en_kb), .en_xor_key_end_i(en_ke),
        .en_xor_lsb_i(en_lsb), .en_tag_i(en_tag), .ready_o(rdy[2]),
        .done_o(dn[2]), .state_o(so[2]), .cypher_o(cy_c),
`ifdef ASCON_PERM_ERR_EN
        .err_o(er[2]),
`endif
        .tag_o(tg[2]));

    function automatic logic [127:0] cyv(input int d);
        if (d == 0) return {64'd0, cy_a};
        if (d == 1) return {64'd0, cy_b};
        return cy_c;
    endfunction

    function automatic logic [63:0] rot(input logic [63:0] x, input int n);
        logic [127:0] dd;
        dd = {x, x};
        return dd[n +: 64];
    endfunction

    // Bit-sliced view: column b of (x0..x4) is one 5-bit S-box lookup.
    function automatic logic [319:0] perm(input logic [319:0] s, input int n);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  v;
        for (int j = 0; j < 5; j++) x[j] = s[319-64*j -: 64];
        for (int i = 12 - n; i < 12; i++) begin
            x[2][7:0] = x[2][7:0] ^ 8'(((15 - i) << 4) | i);
            for (int b = 0; b < 64; b++) begin
                v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                v = SBOX[v];
                for (int j = 0; j < 5; j++) y[j][b] = v[4-j];
            end
            for (int j = 0; j < 5; j++)
                x[j] = y[j] ^ rot(y[j], ROT1[j]) ^ rot(y[j], ROT2[j]);
        end
        for (int j = 0; j < 5; j++) s[319-64*j -: 64] = x[j];
        return s;
    endfunction

    function automatic logic [319:0] rnd320();
        logic [319:0] s;
        for (int j = 0; j < 10; j++) s[32*j +: 32] = $urandom;
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [319:0] got,
                       input logic [319:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [3:0] n,
                         input logic [319:0] s, input logic [127:0] k,
                         input logic [127:0] dt, input logic [4:0] en);
        load  = ld;
        nb    = n;
        st_in = s;
        key   = k;
        data  = dt;
        {en_d, en_kb, en_ke, en_lsb, en_tag} = en;
    endtask

    // en = {data, key_begin, key_end, lsb, tag}
    task automatic op(input logic ld, input logic [3:0] n,
                      input logic [319:0] s, input logic [127:0] k,
                      input logic [127:0] dt, input logic [4:0] en,
                      input bit poke, input string tag);
        logic [319:0] x;
        int first [3];
        int pulses [3];
        for (int d = 0; d < 3; d++) begin
            x = ld ? s : m_st[d];
            if (rr[d] == 64) begin
                if (en[4]) x[319:256] = x[319:256] ^ dt[63:0];
                if (en[3]) x[255:128] = x[255:128] ^ k;
                m_cy[d] = {64'd0, x[319:256]};
            end else begin
                if (en[4]) x[319:192] = x[319:192] ^ dt;
                if (en[3]) x[191:64] = x[191:64] ^ k;
                m_cy[d] = x[319:192];
            end
            x = perm(x, int'(n));
            if (en[2]) x[127:0] = x[127:0] ^ k;
            if (en[1]) x[0] = ~x[0];
            if (en[0]) m_tag[d] = x[127:0];
            m_st[d] = x;
            first[d] = 0;
            pulses[d] = 0;
        end
        drive(ld, n, s, k, dt, en);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                if (dn[d]) begin
                    pulses[d]++;
                    if (first[d] == 0) first[d] = c;
                end
                if (c == 1)
                    chk($sformatf("%s.busy%0d", tag, d),
                        320'(rdy[d]), 320'(0));
            end
            if (poke && c == 1) begin
                drive(1'b1, 4'd8, rnd320(), rnd128(), rnd128(), 5'h1f);
                start = 1'b1;
            end
            if (poke && c == 2) start = 1'b0;
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s.lat%0d", tag, d),
                320'(first[d]), 320'(int'(n) / uu[d] + 1));
            chk($sformatf("%s.pulses%0d", tag, d),
                320'(pulses[d]), 320'(1));
            chk($sformatf("%s.state%0d", tag, d), so[d], m_st[d]);
            chk($sformatf("%s.cypher%0d", tag, d),
                320'(cyv(d)), 320'(m_cy[d]));
            chk($sformatf("%s.tag%0d", tag, d),
                320'(tg[d]), 320'(m_tag[d]));
            chk($sformatf("%s.ready%0d", tag, d), 320'(rdy[d]), 320'(1));
        end
    endtask

    task automatic chk_reset(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s.state%0d", tag, d), so[d], 320'(0));
            chk($sformatf("%s.cypher%0d", tag, d), 320'(cyv(d)), 320'(0));
            chk($sformatf("%s.tag%0d", tag, d), 320'(tg[d]), 320'(0));
            chk($sformatf("%s.ready%0d", tag, d), 320'(rdy[d]), 320'(1));
            chk($sformatf("%s.done%0d", tag, d), 320'(dn[d]), 320'(0));
        end
`ifdef ASCON_PERM_ERR_EN
        chk({tag, ".err"}, 320'(er), 320'(0));
`endif
    endtask

    initial begin
        int quiet [3];
        logic [127:0] k;

        tick();
        tick();
        chk_reset("rst0");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        op(1'b1, 4'd12, {IV_128, 256'd0}, 128'd0, 128'd0,
           5'b00100, 1'b0, "init");

        op(1'b0, 4'd6, '0, rnd128(),
           {64'hfedcba9876543210, 64'h0123456789abcdef},
           5'b10010, 1'b0, "absorb");

        k = rnd128();
        op(1'b1, 4'd8, {IV_128A, k, rnd128()}, k, rnd128(),
           5'b01101, 1'b0, "final");

        op(1'b1, 4'd12, rnd320(), rnd128(), rnd128(),
           5'b11111, 1'b1, "busy");
`ifdef ASCON_PERM_ERR_EN
        chk("busy.err", 320'(er), 320'(7));
`endif

        drive(1'b1, 4'd7, rnd320(), rnd128(), rnd128(), 5'h1f);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int d = 0; d < 3; d++) quiet[d] = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            for (int d = 0; d < 3; d++) quiet[d] += int'(dn[d]);
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("illegal.ready%0d", d), 320'(rdy[d]), 320'(1));
            chk($sformatf("illegal.state%0d", d), so[d], m_st[d]);
            chk($sformatf("illegal.done%0d", d), 320'(quiet[d]), 320'(0));
        end
`ifdef ASCON_PERM_ERR_EN
        chk("illegal.err", 320'(er), 320'(7));
`endif

        drive(1'b1, 4'd12, rnd320(), rnd128(), rnd128(), 5'b11111);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        rst = 1'b1;
        #1;
        chk_reset("rstmid");
        for (int d = 0; d < 3; d++) begin
            m_st[d]  = '0;
            m_cy[d]  = '0;
            m_tag[d] = '0;
            quiet[d] = 0;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            for (int d = 0; d < 3; d++) quiet[d] += int'(dn[d]);
        end
        for (int d = 0; d < 3; d++)
            chk($sformatf("rstmid.nodone%0d", d), 320'(quiet[d]), 320'(0));

        op(1'b0, 4'd12, '0, rnd128(), rnd128(), 5'b10101, 1'b0, "post");

        for (int t = 0; t < 4; t++)
            op(1'($urandom_range(1)),
               4'(nbs[$urandom_range(2)]),
               rnd320(), rnd128(), rnd128(),
               5'($urandom), 1'b0, $sformatf("rand%0d", t));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
